// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide sequencer: FSM state
// encoding, operation encoding and the iteration-counter width helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT  = 3'd1,
    DIV   = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // The counter must hold the value DATA_W itself, hence the extra bit.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the main control unit and the
// multiply/divide sequencer. MULDIV_UNSIGNED_EN adds the is_unsigned
// request qualifier (MULTU/DIVU).
interface muldiv_seq_if #(
  parameter int DATA_W = 32
);

  logic              start;
  logic              is_div;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
`ifdef MULDIV_UNSIGNED_EN
  logic              is_unsigned;
`endif
  logic              busy;
  logic              done;
  logic              div0;
  logic              hi_lo_write;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, is_div, op_a, op_b,
`ifdef MULDIV_UNSIGNED_EN
    output is_unsigned,
`endif
    input  busy, done, div0, hi_lo_write, hi, lo
  );

  modport slave (
    input  start, is_div, op_a, op_b,
`ifdef MULDIV_UNSIGNED_EN
    input  is_unsigned,
`endif
    output busy, done, div0, hi_lo_write, hi, lo
  );

endinterface

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module muldiv_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] divisor,
  input  logic              bit_in,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // rem_in < divisor always holds, so the extra bit is enough to tell
  // whether the trial subtraction went negative.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[DATA_W];
    rem_out = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer feeding HI/LO.
// Optional build macro: MULDIV_UNSIGNED_EN (adds MULTU/DIVU support).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands latched on accept
// MULT  | one Booth radix-2 step per cycle; last step writes HI/LO
// DIV   | one restoring-division step per cycle on magnitudes
// FIXUP | apply quotient/remainder signs, write HI/LO
// DONE  | done pulse (with div0 when the divisor was zero)
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);

  localparam int               CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  // acc_q: Booth accumulator (one guard bit) or division partial remainder.
  // q_q:   multiplier shift register or dividend/quotient shift register.
  // m_q:   multiplicand or divisor magnitude.
  logic [DATA_W:0]   acc_q;
  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] m_q;
  logic              q1_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic              hi_lo_write_q;
  logic              div0_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  logic              busy;
  logic              done;
  logic              accept;
  logic              div_by_zero;
  logic              last_step;

  logic              start_uns;
  logic              uns;

`ifdef MULDIV_UNSIGNED_EN
  logic uns_q;

  assign start_uns = bus.is_unsigned;
  assign uns       = uns_q;

  // Operand signedness is held for the whole operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uns_q <= 1'b0;
    end else if (accept) begin
      uns_q <= bus.is_unsigned;
    end
  end
`else
  assign start_uns = 1'b0;
  assign uns       = 1'b0;
`endif

  logic              sign_a;
  logic              sign_b;
  logic [DATA_W-1:0] abs_a;
  logic [DATA_W-1:0] abs_b;

  // Magnitudes for division; the most-negative value maps to itself,
  // which is the correct unsigned magnitude.
  always_comb begin
    sign_a = ~start_uns & bus.op_a[DATA_W-1];
    sign_b = ~start_uns & bus.op_b[DATA_W-1];
    abs_a  = sign_a ? -bus.op_a : bus.op_a;
    abs_b  = sign_b ? -bus.op_b : bus.op_b;
  end

  logic [DATA_W:0]   m_ext;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   mul_acc_nxt;
  logic [DATA_W-1:0] mul_q_nxt;

  // Booth step (signed) or plain add-shift step (unsigned).
  always_comb begin
    m_ext   = uns ? {1'b0, m_q} : {m_q[DATA_W-1], m_q};
    mul_sum = acc_q;
    if (uns) begin
      if (q_q[0]) mul_sum = acc_q + m_ext;
    end else begin
      case ({q_q[0], q1_q})
        2'b01:   mul_sum = acc_q + m_ext;
        2'b10:   mul_sum = acc_q - m_ext;
        default: mul_sum = acc_q;
      endcase
    end
    mul_acc_nxt = {(uns ? 1'b0 : mul_sum[DATA_W]), mul_sum[DATA_W:1]};
    mul_q_nxt   = {mul_sum[0], q_q[DATA_W-1:1]};
  end

  logic [DATA_W-1:0] div_rem_nxt;
  logic              div_qbit;

  muldiv_div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .rem_in  (acc_q[DATA_W-1:0]),
    .divisor (m_q),
    .bit_in  (q_q[DATA_W-1]),
    .rem_out (div_rem_nxt),
    .q_bit   (div_qbit)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_d     = state_q;
    busy        = 1'b1;
    done        = 1'b0;
    accept      = 1'b0;
    div_by_zero = 1'b0;
    last_step   = (cnt_q == CNT_ONE);
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          if (bus.is_div == OP_DIV && bus.op_b == '0) begin
            div_by_zero = 1'b1;
            state_d     = DONE;
          end else begin
            accept  = 1'b1;
            state_d = (bus.is_div == OP_DIV) ? DIV : MULT;
          end
        end
      end
      MULT:    if (last_step) state_d = DONE;
      DIV:     if (last_step) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latching, iteration datapath, HI/LO and the result strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      acc_q         <= '0;
      q_q           <= '0;
      m_q           <= '0;
      q1_q          <= 1'b0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      hi_lo_write_q <= 1'b0;
      div0_q        <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
    end else begin
      hi_lo_write_q <= 1'b0;
      div0_q        <= div_by_zero;
      if (accept) begin
        cnt_q     <= CNT_LOAD;
        acc_q     <= '0;
        q1_q      <= 1'b0;
        neg_quo_q <= sign_a ^ sign_b;
        neg_rem_q <= sign_a;
        if (bus.is_div == OP_DIV) begin
          q_q <= abs_a;
          m_q <= abs_b;
        end else begin
          q_q <= bus.op_b;
          m_q <= bus.op_a;
        end
      end
      case (state_q)
        MULT: begin
          acc_q <= mul_acc_nxt;
          q_q   <= mul_q_nxt;
          q1_q  <= q_q[0];
          cnt_q <= cnt_q - CNT_ONE;
          if (last_step) begin
            hi_q          <= mul_acc_nxt[DATA_W-1:0];
            lo_q          <= mul_q_nxt;
            hi_lo_write_q <= 1'b1;
          end
        end
        DIV: begin
          acc_q <= {1'b0, div_rem_nxt};
          q_q   <= {q_q[DATA_W-2:0], div_qbit};
          cnt_q <= cnt_q - CNT_ONE;
        end
        FIXUP: begin
          lo_q          <= neg_quo_q ? -q_q : q_q;
          hi_q          <= neg_rem_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
          hi_lo_write_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.div0        = div0_q;
  assign bus.hi_lo_write = hi_lo_write_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
